// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and default sizing for the multiplier arbiter.
//   state_e - arbiter sequencing states (2 bits)
//   Def*    - default requester count, operand width and watchdog limit
//   idx_t   - requester index type for the default requester count
package mul_arb_pkg;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefW       = 4;
  localparam int unsigned DefTimeout = 15;
  localparam int unsigned DefIdxW    = $clog2(DefNreq);

  typedef logic [DefIdxW-1:0] idx_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker.
//   req_i   - request vector
//   ptr_i   - index with highest priority this round
//   found_o - at least one request is set
//   idx_o   - first set request at or after ptr_i, wrapping modulo Nreq
module rr_picker #(
  parameter int unsigned Nreq = 4,
  parameter int unsigned IdxW = $clog2(Nreq)
) (
  input  logic [Nreq-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    // Scan farthest offset first so the candidate nearest ptr_i is the last one written.
    for (int unsigned off = Nreq; off > 0; off--) begin
      cand = (32'(ptr_i) + off - 1) % Nreq;
      if (req_i[IdxW'(cand)]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin scheduler sharing one shift-add multiplier among Nreq requesters.
// Optional feature macro: MUL_ARB_TIMEOUT_EN (WAIT watchdog, reports resp_err_o).
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   req_i, op_a_i, op_b_i  - per-requester request level and packed operand slices
//   gnt_o                  - one-hot one-cycle grant
//   mul_start_o, mul_a_o/b - start pulse and latched operands to the multiplier
//   mul_done_i, mul_result_i - completion and product from the multiplier
//   resp_*                 - valid/ready response carrying requester index and product
//   busy_o                 - arbiter not idle
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned Nreq    = DefNreq,
  parameter int unsigned W       = DefW,
  parameter int unsigned Timeout = DefTimeout,
  localparam int unsigned IdxW   = $clog2(Nreq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [Nreq-1:0]   req_i,
  input  logic [Nreq*W-1:0] op_a_i,
  input  logic [Nreq*W-1:0] op_b_i,
  output logic [Nreq-1:0]   gnt_o,
  output logic              mul_start_o,
  output logic [W-1:0]      mul_a_o,
  output logic [W-1:0]      mul_b_o,
  input  logic              mul_done_i,
  input  logic [2*W-1:0]    mul_result_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [IdxW-1:0]   resp_id_o,
  output logic [2*W-1:0]    resp_data_o,
  output logic              resp_err_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   id_q, id_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [2*W-1:0]    data_q, data_d;
  logic [Nreq-1:0]   gnt_q, gnt_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              found;
  logic [IdxW-1:0]   win;
  logic              timeout;

  rr_picker #(
    .Nreq (Nreq),
    .IdxW (IdxW)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (win)
  );

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(Timeout + 1) > 4) ? $clog2(Timeout + 1) : 4;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign timeout = (cnt_q == CntW'(Timeout - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
      if (mul_done_i) begin
        err_d = 1'b0;
      end else if (timeout) begin
        err_d = 1'b1;
      end
    end else if (state_q == StResp && resp_ready_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err_o = err_q;
`else
  assign timeout    = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    gnt_d   = '0;
    start_d = 1'b0;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StIssue;
          a_d        = op_a_i[32'(win)*W +: W];
          b_d        = op_b_i[32'(win)*W +: W];
          id_d       = win;
          ptr_d      = (win == IdxW'(Nreq - 1)) ? '0 : win + 1'b1;
          gnt_d[win] = 1'b1;
          start_d    = 1'b1;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mul_done_i) begin
          data_d  = mul_result_i;
          state_d = StResp;
          valid_d = 1'b1;
        end else if (timeout) begin
          data_d  = '0;
          state_d = StResp;
          valid_d = 1'b1;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign mul_start_o  = start_q;
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign resp_valid_o = valid_q;
  assign resp_id_o    = id_q;
  assign resp_data_o  = data_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized self-checking bench for mul_arbiter with a behavioural
// multiplier model and a round-robin reference model.
module tb_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] op_a, op_b;
  logic [3:0]  gnt;
  logic        mul_start;
  logic [3:0]  mul_a, mul_b;
  logic        mul_done;
  logic [7:0]  mul_result;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic        busy;

  int tests_run = 0;
  int fails     = 0;
  int model_ptr = 0;
  bit no_done   = 1'b0;
  int lat       = 5;

  always #5 clk = ~clk;

  mul_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .gnt_o        (gnt),
    .mul_start_o  (mul_start),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_done_i   (mul_done),
    .mul_result_i (mul_result),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .busy_o       (busy)
  );

  // Behavioural multiplier: Load + lat cycles after start, then a one-cycle done.
  initial begin
    bit         pending;
    int         cnt;
    logic [7:0] prod;
    pending    = 1'b0;
    cnt        = 0;
    prod       = '0;
    mul_done   = 1'b0;
    mul_result = '0;
    forever begin
      @(posedge clk);
      #2;
      mul_done = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        if (cnt == 0) begin
          if (!no_done) begin
            mul_done   = 1'b1;
            mul_result = prod;
          end
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end else if (mul_start) begin
        pending = 1'b1;
        cnt     = lat;
        prod    = mul_a * mul_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n     = 1'b1;
    model_ptr = 0;
  endtask

  // One full transaction from an IDLE sample point; hold = cycles of resp_ready low in RESP.
  task automatic run_txn(input logic [3:0] rq, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input bit keep_req, input string tag,
                         output int won);
    int         win;
    int         cyc;
    bit         extra_gnt;
    logic [3:0] ea, eb;
    logic [7:0] exp;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (win < 0 && rq[(model_ptr + k) % NREQ]) win = (model_ptr + k) % NREQ;
    end
    won = win;
    ea  = a[win*W +: W];
    eb  = b[win*W +: W];
    exp = ea * eb;
    req        = rq;
    op_a       = a;
    op_b       = b;
    resp_ready = (hold == 0);
    lat        = $urandom_range(5, 8);
    tick();
    tests_run++;
    if ({gnt, mul_start, busy, resp_valid} !== {4'(1 << win), 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL %s issue: gnt/start/busy/valid=%b %b %b %b, required gnt=%b start=1 busy=1 valid=0",
               tag, gnt, mul_start, busy, resp_valid, 4'(1 << win));
    end
    tests_run++;
    if ({mul_a, mul_b} !== {ea, eb}) begin
      fails++;
      $display("FAIL %s operands: mul_a=%0d mul_b=%0d, required %0d %0d", tag, mul_a, mul_b, ea, eb);
    end
    model_ptr = (win + 1) % NREQ;
    if (!keep_req) req = '0;
    tick();
    tests_run++;
    if ({gnt, mul_start} !== 5'b0) begin
      fails++;
      $display("FAIL %s pulse: gnt=%b start=%b one cycle later, required 0", tag, gnt, mul_start);
    end
    cyc       = 1;
    extra_gnt = 1'b0;
    while (resp_valid !== 1'b1 && cyc < 40) begin
      if (gnt !== 4'b0) extra_gnt = 1'b1;
      tick();
      cyc++;
    end
    tests_run++;
    if (resp_valid !== 1'b1 || cyc !== lat + 2 || extra_gnt) begin
      fails++;
      $display("FAIL %s resp_timing: valid=%b after %0d cycles extra_gnt=%0b, required valid after %0d",
               tag, resp_valid, cyc, extra_gnt, lat + 2);
    end
    tests_run++;
    if ({resp_id, resp_data, resp_err, mul_a, mul_b} !== {2'(win), exp, 1'b0, ea, eb}) begin
      fails++;
      $display("FAIL %s resp: id=%0d data=%0d err=%b a=%0d b=%0d, required id=%0d data=%0d err=0",
               tag, resp_id, resp_data, resp_err, mul_a, mul_b, win, exp);
    end
    for (int k = 0; k < hold; k++) begin
      tests_run++;
      if ({resp_valid, busy, gnt, resp_id, resp_data} !== {1'b1, 1'b1, 4'b0, 2'(win), exp}) begin
        fails++;
        $display("FAIL %s hold%0d: valid=%b busy=%b gnt=%b id=%0d data=%0d, required 1 1 0 %0d %0d",
                 tag, k, resp_valid, busy, gnt, resp_id, resp_data, win, exp);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    tests_run++;
    if ({resp_valid, busy, gnt} !== 6'b0) begin
      fails++;
      $display("FAIL %s release: valid=%b busy=%b gnt=%b, required all 0", tag, resp_valid, busy, gnt);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req        = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_data, resp_err, busy} !== '0) begin
      fails++;
      $display("FAIL reset_values: gnt=%b start=%b a=%0d b=%0d valid=%b id=%0d data=%0d err=%b busy=%b",
               gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_data, resp_err, busy);
    end
    rst_n     = 1'b1;
    model_ptr = 0;
    tick();
    tests_run++;
    if ({gnt, busy} !== 5'b0) begin
      fails++;
      $display("FAIL idle_no_req: gnt=%b busy=%b, required 0", gnt, busy);
    end
  endtask

  task automatic test_single();
    int won;
    run_txn(4'b0100, 16'h0700, 16'h0900, 0, 1'b0, "single", won);
    tests_run++;
    if (won !== 2 || resp_data !== 8'd63) begin
      fails++;
      $display("FAIL single_id: winner=%0d data=%0d, required 2 and 63", won, resp_data);
    end
  endtask

  task automatic test_round_robin();
    int won;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_txn(4'hF, 16'($urandom), 16'($urandom), 0, 1'b1, "rr", won);
      tests_run++;
      if (won !== k % NREQ) begin
        fails++;
        $display("FAIL rr_order%0d: winner=%0d, required %0d", k, won, k % NREQ);
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    int won;
    run_txn(4'b0011, 16'($urandom), 16'($urandom), 5, 1'b1, "backpressure", won);
    req = '0;
  endtask

  task automatic test_reset_in_wait();
    int won;
    no_done    = 1'b1;
    req        = 4'b0010;
    op_a       = 16'h0050;
    op_b       = 16'h0030;
    resp_ready = 1'b1;
    tick();
    req = '0;
    tick();
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL wait_state: busy=%b valid=%b, required 1 0", busy, resp_valid);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if ({gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_data, resp_err, busy} !== '0) begin
      fails++;
      $display("FAIL reset_in_wait: gnt=%b start=%b a=%0d b=%0d valid=%b id=%0d data=%0d busy=%b",
               gnt, mul_start, mul_a, mul_b, resp_valid, resp_id, resp_data, busy);
    end
    rst_n     = 1'b1;
    no_done   = 1'b0;
    model_ptr = 0;
    run_txn(4'b1001, 16'($urandom), 16'($urandom), 0, 1'b0, "post_reset_ptr", won);
    tests_run++;
    if (won !== 0) begin
      fails++;
      $display("FAIL ptr_cleared: winner=%0d, required 0", won);
    end
    run_txn(4'b1000, 16'hA000, 16'h3000, 0, 1'b0, "post_reset", won);
    tests_run++;
    if (won !== 3 || resp_id !== 2'd3) begin
      fails++;
      $display("FAIL post_reset_id: winner=%0d id=%0d, required 3", won, resp_id);
    end
  endtask

  task automatic test_edge_operands();
    int won;
    run_txn(4'b0001, 16'h000F, 16'h000F, 0, 1'b0, "max_operands", won);
    tests_run++;
    if (resp_data !== 8'd225) begin
      fails++;
      $display("FAIL max_product: data=%0d, required 225", resp_data);
    end
    run_txn(4'b0001, 16'h0000, 16'h000D, 1, 1'b0, "zero_operand", won);
    tests_run++;
    if (resp_data !== 8'd0) begin
      fails++;
      $display("FAIL zero_product: data=%0d, required 0", resp_data);
    end
  endtask

`ifdef MUL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    no_done    = 1'b1;
    req        = 4'b0100;
    op_a       = 16'h0300;
    op_b       = 16'h0300;
    resp_ready = 1'b1;
    tick();
    req = '0;
    model_ptr = 3;
    tick();
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 8'd0 || cyc !== TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout: valid=%b err=%b data=%0d after %0d cycles, required 1 1 0 after %0d",
               resp_valid, resp_err, resp_data, cyc, TIMEOUT + 1);
    end
    tick();
    tick();
    no_done = 1'b0;
  endtask
`endif

  task automatic test_random();
    int won;
    for (int k = 0; k < 25; k++) begin
      run_txn(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), "random", won);
    end
    req = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    op_a       = '0;
    op_b       = '0;
    resp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_in_wait();
    test_edge_operands();
`ifdef MUL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
